// File: rtl/pipe_stall_apply_unit.sv
// pipe_stall_apply_unit: owns PC, IF/ID and ID/EX control/valid registers and
// applies the stall / flush / redirect commands from hazard detection.
// A small FSM reports pipeline condition; a watchdog flags stuck load-use stalls.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_stall_apply_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              id_ex_flush,
  input  logic              branch_taken,
  input  logic [31:0]       bta,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
  output logic [1:0]        pipe_state,
  output logic              stall_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, REDIRECT = 2'd3} state_t;

  state_t     state, state_nxt;
  logic [7:0] stall_cnt, stall_cnt_nxt;
  logic       load_use;

  // Hazard unit never pairs a redirect with a load-use stall; redirect wins anyway.
  assign load_use   = id_ex_flush & ~branch_taken & ~pc_write;
  assign pipe_state = state;

  // Next state plus watchdog counter. The counter tracks consecutive load-use
  // cycles that keep the FSM in STALL, so after N held stall cycles it reads N.
  always_comb begin
    state_nxt     = RUN;
    stall_cnt_nxt = 8'd0;
    if (state == BOOT)     state_nxt = RUN;
    else if (branch_taken) state_nxt = REDIRECT;
    else if (load_use)     state_nxt = STALL;
    if (state_nxt == STALL)
      stall_cnt_nxt = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;
  end

  // FSM state, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      stall_cnt     <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt >= 8'(MAX_STALL)) stall_timeout <= 1'b1;
    end
  end

  // PC: redirect beats advance; advance wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc <= RESET_PC;
    else if (branch_taken) pc <= bta;
    else if (pc_write)     pc <= pc + 32'd4;
  end

  // IF/ID: redirect squashes to NOP; the BOOT fetch is loaded but marked invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      if_id_pc    <= bta;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (if_id_write) begin
      if_id_pc    <= pc;
      if_id_instr <= imem_instr;
      if_id_valid <= (state != BOOT);
    end
  end

  // ID/EX: flush inserts a zeroed bubble, otherwise take the decoded bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_ctrl  <= '0;
      id_ex_valid <= 1'b0;
    end else if (id_ex_flush) begin
      id_ex_ctrl  <= '0;
      id_ex_valid <= 1'b0;
    end else begin
      id_ex_ctrl  <= id_ctrl;
      id_ex_valid <= if_id_valid;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating event counters: load-use stall cycles and redirect cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (load_use && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (branch_taken && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_apply_unit.sv
// Bench for pipe_stall_apply_unit: directed stimulus, a cycle model in the
// bench compared every cycle, plus literal spot checks from hand calculation.
module tb_pipe_stall_apply_unit;
  localparam int          MAX_STALL = 4;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] IMEM_KEY  = 32'hC0DE_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pc_write = 0, if_id_write = 0, id_ex_flush = 0, branch_taken = 0;
  logic [31:0] bta = 0;
  logic [31:0] imem_instr;
  logic [7:0]  id_ctrl = 0;
  logic [31:0] pc, if_id_pc, if_id_instr;
  logic        if_id_valid, id_ex_valid, stall_timeout;
  logic [7:0]  id_ex_ctrl;
  logic [1:0]  pipe_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // Instruction memory: word content derived from its address.
  assign imem_instr = pc ^ IMEM_KEY;

  pipe_stall_apply_unit #(.MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_flush(id_ex_flush), .branch_taken(branch_taken), .bta(bta),
    .imem_instr(imem_instr), .id_ctrl(id_ctrl), .pc(pc), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .id_ex_ctrl(id_ex_ctrl),
    .id_ex_valid(id_ex_valid), .pipe_state(pipe_state), .stall_timeout(stall_timeout)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one step per clock following the architectural rules directly.
  longint unsigned m_pc, m_if_pc, m_if_instr, m_stall_n, m_flush_n;
  bit  m_if_valid, m_ex_valid, m_to, m_boot;
  int  m_state, m_run;
  logic [7:0] m_ex_ctrl;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_if_pc = 0; m_if_instr = NOP; m_if_valid = 0;
      m_ex_ctrl = 0; m_ex_valid = 0; m_to = 0; m_state = 0; m_run = 0;
      m_boot = 1; m_stall_n = 0; m_flush_n = 0;
    end else begin
      automatic bit lu = id_ex_flush && !branch_taken && !pc_write;
      // ID/EX sees the IF/ID valid bit from before this edge
      m_ex_ctrl  = id_ex_flush ? 8'h00 : id_ctrl;
      m_ex_valid = id_ex_flush ? 1'b0 : m_if_valid;
      if (branch_taken) begin
        m_if_instr = NOP; m_if_valid = 0; m_if_pc = bta;
      end else if (if_id_write) begin
        m_if_instr = (m_pc ^ IMEM_KEY) & 32'hFFFF_FFFF;
        m_if_pc    = m_pc;
        m_if_valid = !m_boot;
      end
      if (branch_taken)  m_pc = bta;
      else if (pc_write) m_pc = (m_pc + 4) % 64'h1_0000_0000;
      m_run = (lu && !m_boot) ? m_run + 1 : 0;
      if (m_run >= MAX_STALL) m_to = 1;
      m_state = m_boot ? 1 : branch_taken ? 3 : (lu ? 2 : 1);
      m_boot  = 0;
      if (lu)           m_stall_n++;
      if (branch_taken) m_flush_n++;
    end
  end

  // Compare process: every cycle outputs are settled and out of reset.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("pc", pc, m_pc[31:0]);
      check("if_id_pc", if_id_pc, m_if_pc[31:0]);
      check("if_id_instr", if_id_instr, m_if_instr[31:0]);
      check("if_id_valid", 32'(if_id_valid), 32'(m_if_valid));
      check("id_ex_ctrl", 32'(id_ex_ctrl), 32'(m_ex_ctrl));
      check("id_ex_valid", 32'(id_ex_valid), 32'(m_ex_valid));
      check("pipe_state", 32'(pipe_state), 32'(m_state));
      check("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_PERF_CNT_EN
      check("perf_stall", perf_stall_cnt, m_stall_n[31:0]);
      check("perf_flush", perf_flush_cnt, m_flush_n[31:0]);
`endif
    end
  end

  task automatic drive(input bit pw, input bit iw, input bit fl, input bit bt,
                       input logic [31:0] tgt, input logic [7:0] ctl);
    pc_write = pw; if_id_write = iw; id_ex_flush = fl; branch_taken = bt;
    bta = tgt; id_ctrl = ctl;
  endtask

  // One clock: inputs applied now, edge, then return at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_if_id_pc"}, if_id_pc, 32'h0);
    check({tag, "_if_id_instr"}, if_id_instr, NOP);
    check({tag, "_if_id_valid"}, 32'(if_id_valid), 32'h0);
    check({tag, "_id_ex_ctrl"}, 32'(id_ex_ctrl), 32'h0);
    check({tag, "_id_ex_valid"}, 32'(id_ex_valid), 32'h0);
    check({tag, "_state"}, 32'(pipe_state), 32'h0);
    check({tag, "_timeout"}, 32'(stall_timeout), 32'h0);
  endtask

  initial begin
    drive(1, 1, 0, 0, 0, 8'h00);
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    // Boot: first edge fetches but IF/ID stays invalid
    drive(1, 1, 0, 0, 0, 8'h11);
    step();
    check("boot_pc1", pc, 32'h4);
    check("boot_valid1", 32'(if_id_valid), 32'h0);
    check("boot_state1", 32'(pipe_state), 32'h1);
    step();
    check("boot_pc2", pc, 32'h8);
    check("boot_valid2", 32'(if_id_valid), 32'h1);
    check("boot_instr2", if_id_instr, 32'hC0DE_0004);
    step(); step();
    check("pre_stall_pc", pc, 32'h10);

    // Single load-use stall at pc=0x10
    drive(0, 0, 1, 0, 0, 8'h5A);
    step();
    check("lu_pc", pc, 32'h10);
    check("lu_if_id_pc", if_id_pc, 32'hC);
    check("lu_ex_valid", 32'(id_ex_valid), 32'h0);
    check("lu_ex_ctrl", 32'(id_ex_ctrl), 32'h0);
    check("lu_state", 32'(pipe_state), 32'h2);
    drive(1, 1, 0, 0, 0, 8'h5A);
    step();
    check("lu_after_state", 32'(pipe_state), 32'h1);
    check("lu_after_ctrl", 32'(id_ex_ctrl), 32'h5A);
    check("lu_after_pc", pc, 32'h14);
    step(); step(); step();
    check("pre_br_pc", pc, 32'h20);

    // Redirect to 0x100
    drive(1, 1, 0, 1, 32'h100, 8'h22);
    step();
    check("br_pc", pc, 32'h100);
    check("br_instr", if_id_instr, NOP);
    check("br_valid", 32'(if_id_valid), 32'h0);
    check("br_state", 32'(pipe_state), 32'h3);
    drive(1, 1, 0, 0, 0, 8'h22);
    step();
    check("br2_pc", pc, 32'h104);
    check("br2_if_id_pc", if_id_pc, 32'h100);
    check("br2_valid", 32'(if_id_valid), 32'h1);

    // Watchdog: four consecutive stall cycles
    drive(0, 0, 1, 0, 0, 8'h33);
    step(); step(); step();
    check("wd_3", 32'(stall_timeout), 32'h0);
    step();
    check("wd_4", 32'(stall_timeout), 32'h1);
    drive(1, 1, 0, 0, 0, 8'h33);
    step();
    check("wd_sticky", 32'(stall_timeout), 32'h1);
    check("wd_state", 32'(pipe_state), 32'h1);

    // PC wrap
    drive(1, 1, 0, 1, 32'hFFFF_FFFC, 8'h44);
    step();
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 0, 8'h44);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_if_id_pc", if_id_pc, 32'hFFFF_FFFC);

    // Async reset mid-stall, away from the edge
    drive(0, 0, 1, 0, 0, 8'h55);
    @(posedge clk);
    #3;
    check("mid_state", 32'(pipe_state), 32'h2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;

    // Perf segment: boot, 3 stalls, 2 separated redirects
    drive(1, 1, 0, 0, 0, 8'h66);
    step();
    drive(0, 0, 1, 0, 0, 8'h66);
    step(); step(); step();
    drive(1, 1, 0, 1, 32'h200, 8'h66);
    step();
    drive(1, 1, 0, 0, 0, 8'h66);
    step();
    drive(1, 1, 0, 1, 32'h300, 8'h66);
    step();
    drive(1, 1, 0, 0, 0, 8'h66);
    step();
    check("perf_pc", pc, 32'h304);
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall_lit", perf_stall_cnt, 32'd3);
    check("perf_flush_lit", perf_flush_cnt, 32'd2);
`endif

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
